// File: rtl/seq_sub_32.sv
// Multi-cycle subtractor: A - B - borrow_in as A + ~B + carry, one lookahead slice per clock.
// Optional ADD_MODE_EN: mode_add sampled at the handshake selects A + B + carry_in instead.
module seq_sub_32 #(
  parameter int WIDTH    = 32,
  parameter int SLICE    = 4,
  parameter int N_SLICES = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  input  logic             mode_add,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for operands; in_ready = 1; last result still visible
  // RUN   | one slice per edge, LSB nibble first
  // DONE  | result valid, held until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNT_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam int IDX_W = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb, acc, acc_nx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] base;
  logic [SLICE:0]   sum;
  logic             carry, a_msb, b_msb, add_q;
  logic             accept, last, res_msb, ovf_nx, mode_sel;

`ifdef ADD_MODE_EN
  assign mode_sel = mode_add;
`else
  logic unused_mode;
  assign mode_sel    = 1'b0;
  assign unused_mode = mode_add;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == CNT_W'(N_SLICES - 1));
  assign base   = IDX_W'(cnt) * IDX_W'(SLICE);
  assign sum    = {1'b0, opa[base +: SLICE]} + {1'b0, opb[base +: SLICE]} + {{SLICE{1'b0}}, carry};

  // The final slice is merged here so diff/overflow come from the complete result.
  always_comb begin
    acc_nx                 = acc;
    acc_nx[base +: SLICE]  = sum[SLICE-1:0];
    res_msb                = acc_nx[WIDTH-1];
    if (add_q) ovf_nx = (a_msb == b_msb) && (res_msb != a_msb);
    else       ovf_nx = (a_msb != b_msb) && (res_msb != a_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      add_q      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= mode_sel ? b : ~b;
      carry <= mode_sel ? borrow_in : ~borrow_in;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      add_q <= mode_sel;
    end else if (state == RUN) begin
      acc   <= acc_nx;
      carry <= sum[SLICE];
      cnt   <= cnt + 1'b1;
      if (last) begin
        cnt        <= '0;
        diff       <= acc_nx;
        borrow_out <= add_q ? sum[SLICE] : ~sum[SLICE];
        overflow   <= ovf_nx;
      end
    end
  end

endmodule
